// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - latency-configurable word RAM behind valid/ready request/response channels
//
// Purpose: data-memory responder for the MEM stage. One transaction is
// outstanding at a time. Stores commit on the accept edge. Loads read the
// word on the accept edge and register the extended result. Faulting
// accesses answer with rsp_err = 1 and rsp_rdata = 0, and leave memory untouched.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-low reset
//   req_valid    request present            req_ready  responder idle, accepts request
//   req_we       1 = store, 0 = load        req_addr   byte address
//   req_wdata    right-aligned store data   req_size   00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned zero-extend loads when 1
//   rsp_valid    response present           rsp_ready  consumer takes response
//   rsp_rdata    load result (0 for stores and errors)
//   rsp_err      access faulted
module dmem_responder #(
  parameter int ENTRY_COUNT = 32,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW = $clog2(ENTRY_COUNT);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LOAD_CNT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [31:0]   mem [ENTRY_COUNT];

  logic          accept;
  logic [IW-1:0] idx;
  logic [1:0]    lane;
  logic          err;
  logic [3:0]    mask;
  logic [31:0]   wdata_lanes;
  logic [31:0]   rword;
  logic [7:0]    byte_val;
  logic [15:0]   half_val;
  logic [31:0]   load_data;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && (state == IDLE);

  // Address decode, fault detection, lane mask and load extraction.
  always_comb begin
    idx         = req_addr[IW+1:2];
    lane        = req_addr[1:0];
    err         = (req_addr[31:IW+2] != '0);
    mask        = 4'b0000;
    wdata_lanes = req_wdata;
    case (req_size)
      2'b00: begin
        mask        = 4'b0001 << lane;
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        if (lane[0]) err = 1'b1;
        mask        = 4'b0011 << {lane[1], 1'b0};
        wdata_lanes = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        if (lane != 2'b00) err = 1'b1;
        mask = 4'b1111;
      end
      default: err = 1'b1;
    endcase

    rword    = mem[idx];
    byte_val = rword[{lane, 3'b000} +: 8];
    half_val = rword[{lane[1], 4'b0000} +: 16];
    case (req_size)
      2'b00:   load_data = {{24{~req_unsigned & byte_val[7]}}, byte_val};
      2'b01:   load_data = {{16{~req_unsigned & half_val[15]}}, half_val};
      default: load_data = rword;
    endcase
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          cnt_next   = LOAD_CNT;
          state_next = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_next = cnt - 1'b1;
        if (cnt == CW'(1)) state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The response is formed at accept and then held until the handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_err   <= err;
      rsp_rdata <= (err || req_we) ? 32'h0 : load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRY_COUNT; i++) mem[i] <= '0;
    end else if (accept && req_we && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) mem[idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (LATENCY 2 and LATENCY 1 instances)
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        sel;

  logic        rv0, rr0, vv0, er0;
  logic        rv1, rr1, vv1, er1;
  logic [31:0] rd0, rd1;

  logic        o_ready, o_valid, o_err;
  logic [31:0] o_rdata;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ref_mem [2][128];

  always #5 clk = ~clk;

  assign rv0     = req_valid && !sel;
  assign rv1     = req_valid && sel;
  assign o_ready = sel ? rr1 : rr0;
  assign o_valid = sel ? vv1 : vv0;
  assign o_rdata = sel ? rd1 : rd0;
  assign o_err   = sel ? er1 : er0;

  dmem_responder #(.ENTRY_COUNT(32), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(rv0), .req_ready(rr0), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(vv0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(er0)
  );

  dmem_responder #(.ENTRY_COUNT(32), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(rv1), .req_ready(rr1), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(vv1), .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(er1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 128; a++) ref_mem[d][a] = 8'h00;
  endtask

  // Byte-addressed reference: faults first, then store or assemble-and-extend.
  task automatic ref_model(input int d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size,
                           input logic uns, output logic [31:0] rdata, output logic err);
    int n;
    logic [31:0] v;
    err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
          (size == 2'd2 && addr[1:0] != 2'd0) || (addr >= 32'd128);
    rdata = 32'h0;
    if (err) return;
    n = 1 << size;
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[d][addr + i] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[d][addr + i]) << (8 * i));
      if (!uns && size == 2'd0 && v[7])  v = v | 32'hFFFFFF00;
      if (!uns && size == 2'd1 && v[15]) v = v | 32'hFFFF0000;
      rdata = v;
    end
  endtask

  task automatic txn(input logic s, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                     input int hold, output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          lat;
    sel = s;
    #1;
    chk("req_ready_idle", {31'b0, o_ready}, 32'd1);
    ref_model(s ? 1 : 0, we, addr, wdata, size, uns, exp_rd, exp_er);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns; rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_unsigned = 1'($urandom);
    lat = 1;
    while (!o_valid && lat < 20) begin
      chk("req_ready_busy", {31'b0, o_ready}, 32'd0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, s ? 32'd1 : 32'd2);
    rd = o_rdata;
    er = o_err;
    chk("rdata", rd, exp_rd);
    chk("err", {31'b0, er}, {31'b0, exp_er});
    chk("req_ready_resp", {31'b0, o_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, o_valid}, 32'd1);
      chk("hold_rdata", o_rdata, rd);
      chk("hold_err", {31'b0, o_err}, {31'b0, er});
      chk("hold_ready", {31'b0, o_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("valid_drop", {31'b0, o_valid}, 32'd0);
    chk("ready_after", {31'b0, o_ready}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    logic [1:0]  sz;

    rst = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_size = '0; req_unsigned = 1'b0; rsp_ready = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, rr0}, 32'd1);
    chk("rst_valid", {31'b0, vv0}, 32'd0);
    chk("rst_rdata", rd0, 32'h0);
    chk("rst_err", {31'b0, er0}, 32'd0);
    chk("rst_valid1", {31'b0, vv1}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed sequence on the LATENCY=2 instance.
    txn(0, 1, 32'h8, 32'hDEADBEEF, 2'd2, 0, 0, rd, er);
    txn(0, 0, 32'h8, 32'h0, 2'd2, 0, 0, rd, er);
    chk("ld_word_8", rd, 32'hDEADBEEF);
    txn(0, 1, 32'h9, 32'h00000080, 2'd0, 0, 0, rd, er);
    txn(0, 0, 32'h9, 32'h0, 2'd0, 0, 0, rd, er);
    chk("ld_byte_signed", rd, 32'hFFFFFF80);
    txn(0, 0, 32'h9, 32'h0, 2'd0, 1, 0, rd, er);
    chk("ld_byte_unsigned", rd, 32'h00000080);
    txn(0, 0, 32'h8, 32'h0, 2'd2, 0, 0, rd, er);
    chk("ld_word_merged", rd, 32'hDEAD80EF);
    txn(0, 1, 32'hA, 32'h00001234, 2'd1, 0, 0, rd, er);
    txn(0, 0, 32'hA, 32'h0, 2'd1, 0, 0, rd, er);
    chk("ld_half", rd, 32'h00001234);
    txn(0, 0, 32'hB, 32'h0, 2'd1, 0, 0, rd, er);
    chk("ld_half_misaligned_err", {31'b0, er}, 32'd1);
    txn(0, 1, 32'h6, 32'hFFFFFFFF, 2'd2, 0, 0, rd, er);
    chk("st_word_misaligned_err", {31'b0, er}, 32'd1);
    txn(0, 0, 32'h4, 32'h0, 2'd2, 0, 0, rd, er);
    chk("word4_untouched", rd, 32'h0);
    txn(0, 1, 32'h80, 32'h11223344, 2'd2, 0, 0, rd, er);
    chk("st_oor_err", {31'b0, er}, 32'd1);
    txn(0, 1, 32'h0, 32'h55667788, 2'd3, 0, 0, rd, er);
    chk("st_size3_err", {31'b0, er}, 32'd1);
    txn(0, 0, 32'h0, 32'h0, 2'd2, 0, 0, rd, er);
    chk("word0_untouched", rd, 32'h0);
    txn(0, 0, 32'h8, 32'h0, 2'd2, 0, 5, rd, er);
    chk("hold_load", rd, 32'h123480EF);

    // LATENCY=1 instance.
    txn(1, 1, 32'h10, 32'hCAFEF00D, 2'd2, 0, 0, rd, er);
    txn(1, 0, 32'h12, 32'h0, 2'd1, 0, 5, rd, er);
    chk("l1_half_signed", rd, 32'hFFFFCAFE);

    // Randomized traffic on both instances.
    for (int i = 0; i < 120; i++) begin
      a  = $urandom_range(0, 140);
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      txn(1'($urandom), 1'($urandom), a, $urandom, sz, 1'($urandom),
          $urandom_range(0, 3), rd, er);
    end

    // Reset while the LATENCY=2 instance is in WAIT abandons the load.
    sel = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8; req_size = 2'd2; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("wait_valid_low", {31'b0, vv0}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    chk("abort_ready", {31'b0, rr0}, 32'd1);
    chk("abort_valid", {31'b0, vv0}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", {31'b0, vv0}, 32'd0);
    end
    for (int i = 0; i < 6; i++) begin
      a = 32'($urandom_range(0, 31)) << 2;
      txn(1'(i & 1), 0, a, 32'h0, 2'd2, 0, 0, rd, er);
      chk("post_reset_zero", rd, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
